// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage register file for a 4-bit-indexed, 32-bit datapath.
// Holds R0..R14. Reads of R15 return PCPlus8D. Also counts the cycles that commit a writeback.
// Optional feature: define WB_BYPASS_EN to make decode reads write-through (same-cycle forwarding).
module wb_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ReadDataW,
    input  logic [31:0] ALUOutW,
    input  logic [3:0]  WA3W,
    input  logic        MemtoRegW,
    input  logic        PCSrcW,
    input  logic        RegWriteW,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [31:0] PCPlus8D,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [31:0] ResultW,
    output logic [31:0] RetireCount
);

    localparam int NUM_REGS = 15;
    localparam logic [3:0] PC_INDEX = 4'd15;

    logic [31:0] regs_reg [NUM_REGS];
    logic [31:0] retire_count_reg;
    logic [3:0]  read_addr [2];
    logic [31:0] read_data [2];

    // Writeback value selection: load data or ALU result, no reset dependency.
    always_comb begin
        ResultW = MemtoRegW ? ReadDataW : ALUOutW;
    end

    // One storage slot per architectural register. A WA3W of 15 never
    // matches any slot, so PC writes are dropped here and handled by fetch.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // Register gi: cleared while reset is held, loaded on a matching write.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    regs_reg[gi] <= '0;
                end else if (RegWriteW && (WA3W == 4'(gi))) begin
                    regs_reg[gi] <= ResultW;
                end
            end
        end
    endgenerate

    assign read_addr[0] = RA1D;
    assign read_addr[1] = RA2D;

    // Both decode read ports share the same structure, including the R15 and bypass paths.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            // Read mux for port gi: R15 returns PC+8, otherwise the stored value.
            always_comb begin
                read_data[gi] = '0;
                if (read_addr[gi] == PC_INDEX) begin
                    read_data[gi] = PCPlus8D;
                end else begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (read_addr[gi] == 4'(i)) begin
                            read_data[gi] = regs_reg[i];
                        end
                    end
`ifdef WB_BYPASS_EN
                    // Write-through: a write to the register being read shows up
                    // in the same cycle, so decode needs no extra stall.
                    if (RegWriteW && (WA3W == read_addr[gi])) begin
                        read_data[gi] = ResultW;
                    end
`endif
                end
            end
        end
    endgenerate

    assign RD1D = read_data[0];
    assign RD2D = read_data[1];

    // Retire counter: one increment per committed writeback (register or PC), wraps silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_count_reg <= '0;
        end else if (RegWriteW || PCSrcW) begin
            retire_count_reg <= retire_count_reg + 32'd1;
        end
    end

    assign RetireCount = retire_count_reg;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have rst_n  in  1  reset, synchronous and active-low.
REQ-003 SHALL have ReadDataW  in  32  load data from the MEM/WB register.
REQ-004 SHALL have ALUOutW  in  32  ALU result from the MEM/WB register.
REQ-005 SHALL have WA3W  in  4  destination register index.
REQ-006 SHALL have MemtoRegW, PCSrcW, RegWriteW  in  1 each  writeback controls from the MEM/WB register.
REQ-007 SHALL have RA1D, RA2D  in  4 each  decode-stage read indices.
REQ-008 SHALL have PCPlus8D  in  32  value returned for R15 reads.
REQ-009 SHALL have RD1D, RD2D  out  32 each  read data to decode.
REQ-010 SHALL have ResultW  out  32  selected writeback value, also feeding the fetch PC mux and the forwarding logic.
REQ-011 SHALL have RetireCount  out  32  count of cycles with a committed writeback.

Function
REQ-012 SHALL compute ResultW combinationally: ReadDataW when MemtoRegW=1, else ALUOutW.
REQ-013 SHALL hold 15 architectural registers R0..R14, each 32 bits; R15 SHALL NOT be stored.
REQ-014 SHALL write ResultW into R[WA3W] on a rising clk edge when rst_n=1, RegWriteW=1 and WA3W!=15.
REQ-015 SHALL ignore writes with WA3W=15; PC update is owned by fetch via PCSrcW/ResultW.
REQ-016 SHALL drive RDxD combinationally: PCPlus8D when RAxD=15, else R[RAxD], subject to REQ-024.
REQ-017 SHALL allow RA1D=RA2D; both ports then return identical data.
REQ-018 SHALL increment RetireCount by 1 on each rising edge with rst_n=1 and (RegWriteW | PCSrcW)=1, including WA3W=15 writes.
REQ-019 SHALL wrap RetireCount from 0xFFFFFFFF to 0x00000000 without a flag.
REQ-020 SHALL have zero-cycle latency from control inputs to ResultW and one-edge latency from write to register contents.

Reset
REQ-021 SHALL clear R0..R14 and RetireCount to 0 on any rising edge with rst_n=0.
REQ-022 SHALL suppress register writes and counter increments on any edge with rst_n=0, including RegWriteW=1 arriving mid-reset.
REQ-023 SHALL keep ResultW, and RDxD for RAxD=15, purely combinational and unaffected by rst_n; RDxD for other indices reads 0 from the first edge after reset is sampled.

Configuration
REQ-024 WB_BYPASS_EN defined: when RegWriteW=1, WA3W=RAxD and RAxD!=15, RDxD SHALL return the current ResultW (write-through, same cycle), and this SHALL also apply when rst_n=0.
REQ-025 WB_BYPASS_EN undefined: RDxD SHALL return the pre-write register value until after the write edge; the hazard unit must then stall decode one extra cycle.

Verification
REQ-026 Reset: rst_n=0 for 2 edges with RegWriteW=1, WA3W=3 -> R0..R14=0, RetireCount=0, no write to R3.
REQ-027 Write/read: MemtoRegW=0, ALUOutW=0x12345678, WA3W=5, RegWriteW=1, 1 edge; RA1D=5 -> RD1D=0x12345678, RetireCount=1.
REQ-028 Load select and R15: MemtoRegW=1, ReadDataW=0xCAFEF00D, WA3W=15, RegWriteW=1, PCSrcW=1 -> ResultW=0xCAFEF00D, no register changes, RetireCount+1; RA2D=15, PCPlus8D=0x108 -> RD2D=0x108.
REQ-029 Same-cycle hazard: R7=0x11, write ALUOutW=0x22 to WA3W=7 with RA1D=RA2D=7 before the edge -> RD1D=RD2D=0x22 with WB_BYPASS_EN, 0x11 without; both read 0x22 after the edge.
REQ-030 Counter wrap: preload RetireCount to 0xFFFFFFFF via 2^32-1 commits or a bench-forced value, one more commit -> 0x00000000.
REQ-031 Idle: RegWriteW=0, PCSrcW=0 for 10 edges with varying WA3W/ResultW -> registers and RetireCount unchanged.
